// File: rtl/cache_assoc_param.sv
// Fully-associative write-back/write-allocate cache with true-LRU replacement.
// Misses write back a dirty victim and fill from memory over a req/ack handshake.
module cache_assoc_param #(
    parameter int WAYS   = 4,
    parameter int TAG_W  = 7,
    parameter int DATA_W = 5
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic              Write,
    input  logic [TAG_W-1:0]  Tag_Input,
    input  logic [DATA_W-1:0] BlockIn,
    output logic              Resp_Valid,
    output logic [DATA_W-1:0] BlockOut,
    output logic              hit,
    output logic              M_Req,
    input  logic              M_Ack,
    output logic              C_Write_M,
    output logic [TAG_W-1:0]  Tag_Output,
    output logic [DATA_W-1:0] C_Block_M,
    input  logic [DATA_W-1:0] M_Block_C,
    output logic [2:0]        dbg_state
);
    localparam int AW = $clog2(WAYS);

    // Request side: valid/ready transfer on a rising edge with both high.
    // Memory side: M_Req holds address/data stable until the M_Ack edge.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_WB     = 3'd2,
        S_FILL   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t state, state_next;

    logic [WAYS-1:0]   valid, dirty;
    logic [TAG_W-1:0]  tag_q  [WAYS];
    logic [DATA_W-1:0] data_q [WAYS];
    logic [AW-1:0]     age      [WAYS];
    logic [AW-1:0]     age_next [WAYS];

    logic              req_write;
    logic [TAG_W-1:0]  req_tag;
    logic [DATA_W-1:0] req_data;
    logic [AW-1:0]     victim;
    logic              hit_q;
    logic [DATA_W-1:0] block_q;

    logic              hit_any, inv_any, touch_en;
    logic [AW-1:0]     hit_way, inv_way, lru_way, vict_sel, touch_way;
    logic [DATA_W-1:0] fill_data;

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        lru_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (!hit_any && valid[i] && tag_q[i] == req_tag) begin
                hit_any = 1'b1;
                hit_way = AW'(i);
            end
            if (!inv_any && !valid[i]) begin
                inv_any = 1'b1;
                inv_way = AW'(i);
            end
            if (age[i] == AW'(WAYS - 1))
                lru_way = AW'(i);
        end
        vict_sel = inv_any ? inv_way : lru_way;
    end

    // Touch promotes one line to MRU and ages every line that was younger.
    always_comb begin
        touch_en  = (state == S_LOOKUP && hit_any) || (state == S_FILL && M_Ack);
        touch_way = (state == S_LOOKUP) ? hit_way : victim;
        for (int i = 0; i < WAYS; i++) begin
            age_next[i] = age[i];
            if (touch_en) begin
                if (AW'(i) == touch_way)
                    age_next[i] = '0;
                else if (age[i] < age[touch_way])
                    age_next[i] = age[i] + AW'(1);
            end
        end
    end

    assign fill_data = req_write ? req_data : M_Block_C;

    always_ff @(posedge Clock) begin
        if (Reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (Req_Valid) state_next = S_LOOKUP;
            S_LOOKUP: begin
                if (hit_any)
                    state_next = S_RESP;
                else if (valid[vict_sel] && dirty[vict_sel])
                    state_next = S_WB;
                else
                    state_next = S_FILL;
            end
            S_WB:     if (M_Ack) state_next = S_FILL;
            S_FILL:   if (M_Ack) state_next = S_RESP;
            S_RESP:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        Req_Ready  = (state == S_IDLE);
        Resp_Valid = (state == S_RESP);
        M_Req      = (state == S_WB) || (state == S_FILL);
        C_Write_M  = (state == S_WB);
        Tag_Output = '0;
        C_Block_M  = '0;
        if (state == S_WB) begin
            Tag_Output = tag_q[victim];
            C_Block_M  = data_q[victim];
        end else if (state == S_FILL) begin
            Tag_Output = req_tag;
        end
        BlockOut  = block_q;
        hit       = hit_q;
        dbg_state = state;
    end

    // Result registers load only on the edge entering RESP, so they hold between responses.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            valid     <= '0;
            dirty     <= '0;
            req_write <= 1'b0;
            req_tag   <= '0;
            req_data  <= '0;
            victim    <= '0;
            hit_q     <= 1'b0;
            block_q   <= '0;
            for (int i = 0; i < WAYS; i++) begin
                age[i]    <= AW'(i);
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WAYS; i++)
                age[i] <= age_next[i];
            case (state)
                S_IDLE: begin
                    if (Req_Valid) begin
                        req_write <= Write;
                        req_tag   <= Tag_Input;
                        req_data  <= BlockIn;
                    end
                end
                S_LOOKUP: begin
                    if (hit_any) begin
                        hit_q <= 1'b1;
                        if (req_write) begin
                            data_q[hit_way] <= req_data;
                            dirty[hit_way]  <= 1'b1;
                            block_q         <= req_data;
                        end else begin
                            block_q <= data_q[hit_way];
                        end
                    end else begin
                        victim <= vict_sel;
                    end
                end
                S_WB: begin
                    if (M_Ack)
                        dirty[victim] <= 1'b0;
                end
                S_FILL: begin
                    if (M_Ack) begin
                        tag_q[victim]  <= req_tag;
                        valid[victim]  <= 1'b1;
                        data_q[victim] <= fill_data;
                        dirty[victim]  <= req_write;
                        block_q        <= fill_data;
                        hit_q          <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_assoc_param.sv
// Directed bench for cache_assoc_param: hit/miss paths, write-back, stall, reset abort, back-to-back.
module tb_cache_assoc_param;
    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Req_Valid = 1'b0;
    logic       Req_Ready;
    logic       Write = 1'b0;
    logic [6:0] Tag_Input = '0;
    logic [4:0] BlockIn = '0;
    logic       Resp_Valid;
    logic [4:0] BlockOut;
    logic       hit;
    logic       M_Req;
    logic       M_Ack = 1'b0;
    logic       C_Write_M;
    logic [6:0] Tag_Output;
    logic [4:0] C_Block_M;
    logic [4:0] M_Block_C = '0;
    logic [2:0] dbg_state;

    int compared = 0;
    int mismatched = 0;
    int cyc_cnt = 0;

    cache_assoc_param #(.WAYS(4), .TAG_W(7), .DATA_W(5)) dut (
        .Clock(Clock), .Reset(Reset), .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
        .Write(Write), .Tag_Input(Tag_Input), .BlockIn(BlockIn), .Resp_Valid(Resp_Valid),
        .BlockOut(BlockOut), .hit(hit), .M_Req(M_Req), .M_Ack(M_Ack), .C_Write_M(C_Write_M),
        .Tag_Output(Tag_Output), .C_Block_M(C_Block_M), .M_Block_C(M_Block_C),
        .dbg_state(dbg_state)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc_cnt <= cyc_cnt + 1;

    // Ages must stay a permutation of 0..3 whenever a response (and hence a touch) lands.
    always @(negedge Clock) begin
        if (Resp_Valid) begin
            logic [3:0] seen;
            seen = '0;
            for (int i = 0; i < 4; i++) seen[dut.age[i]] = 1'b1;
            compared++;
            if (seen !== 4'hf) begin mismatched++; $display("FAIL age_perm: got mask %b exp 1111", seen); end
        end
    end

    task automatic send_req(input logic w, input logic [6:0] t, input logic [4:0] d);
        Req_Valid = 1'b1; Write = w; Tag_Input = t; BlockIn = d;
        for (int i = 0; i < 20 && !Req_Ready; i++) begin @(posedge Clock); #1; end
        compared++;
        if (Req_Ready !== 1'b1) begin mismatched++; $display("FAIL req_accept: got ready %b exp 1", Req_Ready); end
        @(posedge Clock); #1;
        Req_Valid = 1'b0;
    endtask

    task automatic mem_serve(input int delay, input logic [4:0] fill, output logic seen,
                             output logic w, output logic [6:0] t, output logic [4:0] b);
        for (int i = 0; i < 20 && !M_Req; i++) begin @(posedge Clock); #1; end
        seen = M_Req; w = C_Write_M; t = Tag_Output; b = C_Block_M;
        if (seen) begin
            repeat (delay) begin @(posedge Clock); #1; end
            M_Ack = 1'b1; M_Block_C = fill;
            @(posedge Clock); #1;
            M_Ack = 1'b0; M_Block_C = '0;
        end
    endtask

    task automatic wait_resp(output logic seen, output int cyc, output logic h,
                             output logic [4:0] b, output logic mreq_seen, output int at);
        seen = 1'b0; cyc = 0; mreq_seen = 1'b0; h = 1'b0; b = '0; at = 0;
        for (int i = 0; i < 20; i++) begin
            if (Resp_Valid) begin seen = 1'b1; h = hit; b = BlockOut; at = cyc_cnt; break; end
            if (M_Req) mreq_seen = 1'b1;
            @(posedge Clock); #1; cyc++;
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1; Reset = 1'b0;
        compared++; if (Req_Ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready: got %b exp 1", Req_Ready); end
        compared++; if (Resp_Valid !== 1'b0) begin mismatched++; $display("FAIL rst_resp: got %b exp 0", Resp_Valid); end
        compared++; if (M_Req !== 1'b0) begin mismatched++; $display("FAIL rst_mreq: got %b exp 0", M_Req); end
        compared++; if (hit !== 1'b0) begin mismatched++; $display("FAIL rst_hit: got %b exp 0", hit); end
        compared++; if (BlockOut !== 5'd0) begin mismatched++; $display("FAIL rst_blk: got %0d exp 0", BlockOut); end
        compared++; if ({C_Write_M, Tag_Output, C_Block_M} !== 13'd0) begin mismatched++; $display("FAIL rst_mem_out: got %h exp 0", {C_Write_M, Tag_Output, C_Block_M}); end
        for (int i = 0; i < 4; i++) begin
            compared++; if (dut.age[i] !== 2'(i)) begin mismatched++; $display("FAIL rst_age%0d: got %0d exp %0d", i, dut.age[i], i); end
        end
    endtask

    task automatic test_read_miss_hit;
        logic s, w, h, mr; logic [6:0] t; logic [4:0] b, bo; int c, at;
        send_req(1'b0, 7'd100, 5'd0);
        mem_serve(1, 5'd10, s, w, t, b);
        compared++; if ({s, w, t} !== {1'b1, 1'b0, 7'd100}) begin mismatched++; $display("FAIL t1_fill_req: got s%b w%b tag %0d exp s1 w0 tag 100", s, w, t); end
        wait_resp(s, c, h, bo, mr, at);
        compared++; if ({s, c} !== {1'b1, 32'd0}) begin mismatched++; $display("FAIL t1_miss_lat: got s%b cyc %0d exp s1 cyc 0", s, c); end
        compared++; if ({h, bo} !== {1'b0, 5'd10}) begin mismatched++; $display("FAIL t1_miss_resp: got hit %b blk %0d exp 0 10", h, bo); end
        send_req(1'b0, 7'd100, 5'd0);
        wait_resp(s, c, h, bo, mr, at);
        compared++; if ({s, c + 1} !== {1'b1, 32'd2}) begin mismatched++; $display("FAIL t1_hit_lat: got s%b lat %0d exp s1 lat 2", s, c + 1); end
        compared++; if ({h, bo, mr} !== {1'b1, 5'd10, 1'b0}) begin mismatched++; $display("FAIL t1_hit_resp: got hit %b blk %0d mreq %b exp 1 10 0", h, bo, mr); end
    endtask

    task automatic test_write_miss;
        logic s, w, h, mr; logic [6:0] t; logic [4:0] b, bo; int c, at;
        send_req(1'b1, 7'd101, 5'd7);
        mem_serve(2, 5'd20, s, w, t, b);
        compared++; if ({s, w, t} !== {1'b1, 1'b0, 7'd101}) begin mismatched++; $display("FAIL t2_fill_req: got s%b w%b tag %0d exp s1 w0 tag 101", s, w, t); end
        wait_resp(s, c, h, bo, mr, at);
        compared++; if ({s, h, bo} !== {1'b1, 1'b0, 5'd7}) begin mismatched++; $display("FAIL t2_wmiss_resp: got s%b hit %b blk %0d exp s1 0 7", s, h, bo); end
        send_req(1'b0, 7'd101, 5'd0);
        wait_resp(s, c, h, bo, mr, at);
        compared++; if ({s, h, bo, mr} !== {1'b1, 1'b1, 5'd7, 1'b0}) begin mismatched++; $display("FAIL t2_rhit: got s%b hit %b blk %0d mreq %b exp s1 1 7 0", s, h, bo, mr); end
    endtask

    task automatic test_evict;
        logic s, w, h, mr; logic [6:0] t; logic [4:0] b, bo; int c, at;
        send_req(1'b0, 7'd102, 5'd0); mem_serve(1, 5'd12, s, w, t, b); wait_resp(s, c, h, bo, mr, at);
        compared++; if ({t, bo} !== {7'd102, 5'd12}) begin mismatched++; $display("FAIL t3_fill102: got tag %0d blk %0d exp 102 12", t, bo); end
        send_req(1'b0, 7'd103, 5'd0); mem_serve(3, 5'd13, s, w, t, b); wait_resp(s, c, h, bo, mr, at);
        compared++; if ({t, bo} !== {7'd103, 5'd13}) begin mismatched++; $display("FAIL t3_fill103: got tag %0d blk %0d exp 103 13", t, bo); end
        send_req(1'b0, 7'd100, 5'd0); wait_resp(s, c, h, bo, mr, at);
        compared++; if ({h, bo, mr} !== {1'b1, 5'd10, 1'b0}) begin mismatched++; $display("FAIL t3_hit100: got hit %b blk %0d mreq %b exp 1 10 0", h, bo, mr); end
        send_req(1'b0, 7'd104, 5'd0);
        mem_serve(1, 5'd0, s, w, t, b);
        compared++; if ({s, w, t, b} !== {1'b1, 1'b1, 7'd101, 5'd7}) begin mismatched++; $display("FAIL t3_wb: got s%b w%b tag %0d blk %0d exp s1 w1 101 7", s, w, t, b); end
        mem_serve(2, 5'd14, s, w, t, b);
        compared++; if ({s, w, t} !== {1'b1, 1'b0, 7'd104}) begin mismatched++; $display("FAIL t3_fill104: got s%b w%b tag %0d exp s1 w0 104", s, w, t); end
        wait_resp(s, c, h, bo, mr, at);
        compared++; if ({s, h, bo} !== {1'b1, 1'b0, 5'd14}) begin mismatched++; $display("FAIL t3_resp104: got s%b hit %b blk %0d exp s1 0 14", s, h, bo); end
        send_req(1'b0, 7'd101, 5'd0);
        mem_serve(1, 5'd15, s, w, t, b);
        compared++; if ({s, w, t} !== {1'b1, 1'b0, 7'd101}) begin mismatched++; $display("FAIL t3_refill101: got s%b w%b tag %0d exp s1 w0 101", s, w, t); end
        wait_resp(s, c, h, bo, mr, at);
        compared++; if ({h, bo} !== {1'b0, 5'd15}) begin mismatched++; $display("FAIL t3_resp101: got hit %b blk %0d exp 0 15", h, bo); end
    endtask

    task automatic test_stall;
        logic s, h, mr; logic [4:0] bo; int c, at;
        send_req(1'b0, 7'd105, 5'd0);
        for (int i = 0; i < 20 && !M_Req; i++) begin @(posedge Clock); #1; end
        for (int i = 0; i < 5; i++) begin
            Req_Valid = i[0]; Write = 1'b1; Tag_Input = 7'd50; BlockIn = 5'd1;
            compared++; if ({M_Req, C_Write_M, Tag_Output, Req_Ready} !== {1'b1, 1'b0, 7'd105, 1'b0}) begin mismatched++; $display("FAIL t4_stall%0d: got mreq %b w %b tag %0d ready %b exp 1 0 105 0", i, M_Req, C_Write_M, Tag_Output, Req_Ready); end
            @(posedge Clock); #1;
        end
        Req_Valid = 1'b0;
        M_Ack = 1'b1; M_Block_C = 5'd16;
        @(posedge Clock); #1;
        M_Ack = 1'b0; M_Block_C = '0;
        wait_resp(s, c, h, bo, mr, at);
        compared++; if ({s, c, h, bo} !== {1'b1, 32'd0, 1'b0, 5'd16}) begin mismatched++; $display("FAIL t4_resp: got s%b cyc %0d hit %b blk %0d exp s1 0 0 16", s, c, h, bo); end
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        compared++; if ({Req_Ready, M_Req, Resp_Valid} !== 3'b100) begin mismatched++; $display("FAIL t4_idle_after: got %b exp 100", {Req_Ready, M_Req, Resp_Valid}); end
    endtask

    task automatic test_reset_in_wb;
        logic s, w, h, mr; logic [6:0] t; logic [4:0] b, bo; int c, at;
        send_req(1'b1, 7'd106, 5'd9); mem_serve(1, 5'd17, s, w, t, b); wait_resp(s, c, h, bo, mr, at);
        compared++; if ({h, bo} !== {1'b0, 5'd9}) begin mismatched++; $display("FAIL t5_w106: got hit %b blk %0d exp 0 9", h, bo); end
        send_req(1'b1, 7'd107, 5'd4); mem_serve(2, 5'd2, s, w, t, b); wait_resp(s, c, h, bo, mr, at);
        send_req(1'b0, 7'd108, 5'd0); mem_serve(1, 5'd18, s, w, t, b); wait_resp(s, c, h, bo, mr, at);
        send_req(1'b0, 7'd109, 5'd0); mem_serve(1, 5'd19, s, w, t, b); wait_resp(s, c, h, bo, mr, at);
        compared++; if ({w, t, bo} !== {1'b0, 7'd109, 5'd19}) begin mismatched++; $display("FAIL t5_r109: got w%b tag %0d blk %0d exp w0 109 19", w, t, bo); end
        send_req(1'b0, 7'd110, 5'd0);
        for (int i = 0; i < 20 && !M_Req; i++) begin @(posedge Clock); #1; end
        compared++; if ({M_Req, C_Write_M, Tag_Output, C_Block_M} !== {1'b1, 1'b1, 7'd106, 5'd9}) begin mismatched++; $display("FAIL t5_wb: got mreq %b w %b tag %0d blk %0d exp 1 1 106 9", M_Req, C_Write_M, Tag_Output, C_Block_M); end
        Reset = 1'b1;
        @(posedge Clock); #1;
        compared++; if ({M_Req, Req_Ready, Resp_Valid} !== 3'b010) begin mismatched++; $display("FAIL t5_rst_abort: got %b exp 010", {M_Req, Req_Ready, Resp_Valid}); end
        Reset = 1'b0; M_Ack = 1'b1; M_Block_C = 5'd30;
        @(posedge Clock); #1;
        M_Ack = 1'b0; M_Block_C = '0;
        compared++; if ({M_Req, Req_Ready, Resp_Valid, hit, BlockOut} !== {3'b010, 1'b0, 5'd0}) begin mismatched++; $display("FAIL t5_late_ack: got %b exp 010000000", {M_Req, Req_Ready, Resp_Valid, hit, BlockOut}); end
        send_req(1'b0, 7'd109, 5'd0);
        mem_serve(1, 5'd21, s, w, t, b);
        compared++; if ({s, w, t} !== {1'b1, 1'b0, 7'd109}) begin mismatched++; $display("FAIL t5_miss109: got s%b w%b tag %0d exp s1 w0 109", s, w, t); end
        wait_resp(s, c, h, bo, mr, at);
        compared++; if ({h, bo} !== {1'b0, 5'd21}) begin mismatched++; $display("FAIL t5_resp109: got hit %b blk %0d exp 0 21", h, bo); end
    endtask

    task automatic test_write_hit_dirty;
        logic s, w, h, mr; logic [6:0] t; logic [4:0] b, bo; int c, at;
        send_req(1'b1, 7'd101, 5'd7); mem_serve(1, 5'd22, s, w, t, b); wait_resp(s, c, h, bo, mr, at);
        compared++; if ({t, h, bo} !== {7'd101, 1'b0, 5'd7}) begin mismatched++; $display("FAIL t6_wmiss: got tag %0d hit %b blk %0d exp 101 0 7", t, h, bo); end
        send_req(1'b1, 7'd101, 5'd3); wait_resp(s, c, h, bo, mr, at);
        compared++; if ({s, c + 1, h, bo, mr} !== {1'b1, 32'd2, 1'b1, 5'd3, 1'b0}) begin mismatched++; $display("FAIL t6_whit: got s%b lat %0d hit %b blk %0d mreq %b exp s1 2 1 3 0", s, c + 1, h, bo, mr); end
        send_req(1'b0, 7'd101, 5'd0); wait_resp(s, c, h, bo, mr, at);
        compared++; if ({h, bo, mr} !== {1'b1, 5'd3, 1'b0}) begin mismatched++; $display("FAIL t6_rhit: got hit %b blk %0d mreq %b exp 1 3 0", h, bo, mr); end
    endtask

    task automatic test_back_to_back;
        logic s, h, mr; logic [4:0] bo; int c, at1, at2;
        send_req(1'b0, 7'd109, 5'd0); wait_resp(s, c, h, bo, mr, at1);
        compared++; if ({h, bo} !== {1'b1, 5'd21}) begin mismatched++; $display("FAIL b2b_first: got hit %b blk %0d exp 1 21", h, bo); end
        send_req(1'b0, 7'd101, 5'd0); wait_resp(s, c, h, bo, mr, at2);
        compared++; if ({h, bo} !== {1'b1, 5'd3}) begin mismatched++; $display("FAIL b2b_second: got hit %b blk %0d exp 1 3", h, bo); end
        compared++; if (at2 - at1 !== 3) begin mismatched++; $display("FAIL b2b_period: got %0d exp 3", at2 - at1); end
    endtask

    initial begin
        test_reset;
        test_read_miss_hit;
        test_write_miss;
        test_evict;
        test_stall;
        test_reset_in_wb;
        test_write_hit_dirty;
        test_back_to_back;
        repeat (2) @(posedge Clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
